// File: rtl/id_stage_pipelined.sv
// Decode stage: instruction decode, register file read and the ID/EX slot.
// The slot has a valid/ready handshake on both sides. Instructions that fail
// their condition still occupy the slot but carry no side effects.

// Condition field evaluation against NZCV (status[3]=N, [2]=Z, [1]=C, [0]=V).
module id_cond_check (
  input  logic [3:0] i_status,
  input  logic [3:0] i_cond,
  output logic       o_pass
);
  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = i_status;

  // Standard condition mnemonics; 1110 and 1111 always pass.
  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      4'b0000: o_pass = w_z;
      4'b0001: o_pass = !w_z;
      4'b0010: o_pass = w_c;
      4'b0011: o_pass = !w_c;
      4'b0100: o_pass = w_n;
      4'b0101: o_pass = !w_n;
      4'b0110: o_pass = w_v;
      4'b0111: o_pass = !w_v;
      4'b1000: o_pass = w_c && !w_z;
      4'b1001: o_pass = !w_c || w_z;
      4'b1010: o_pass = (w_n == w_v);
      4'b1011: o_pass = (w_n != w_v);
      4'b1100: o_pass = !w_z && (w_n == w_v);
      4'b1101: o_pass = w_z || (w_n != w_v);
      default: o_pass = 1'b1;
    endcase
  end
endmodule

// Main decoder: mode 00 data processing, 01 load/store (S=1 load), 10 branch.
module id_controller (
  input  logic [1:0] i_mode,
  input  logic [3:0] i_opcode,
  input  logic       i_s,
  output logic [3:0] o_alu_cmd,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_wb_en,
  output logic       o_branch,
  output logic       o_s_update
);
  // Unknown opcodes and mode 11 decode to a no-op with every control low.
  always_comb begin
    o_alu_cmd   = 4'd0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_wb_en     = 1'b0;
    o_branch    = 1'b0;
    o_s_update  = 1'b0;
    case (i_mode)
      2'b00: begin
        o_s_update = i_s;
        o_wb_en    = 1'b1;
        case (i_opcode)
          4'b1101: o_alu_cmd = 4'd1;  // MOV
          4'b1111: o_alu_cmd = 4'd9;  // MVN
          4'b0100: o_alu_cmd = 4'd2;  // ADD
          4'b0101: o_alu_cmd = 4'd3;  // ADC
          4'b0010: o_alu_cmd = 4'd4;  // SUB
          4'b0110: o_alu_cmd = 4'd5;  // SBC
          4'b0000: o_alu_cmd = 4'd6;  // AND
          4'b1100: o_alu_cmd = 4'd7;  // ORR
          4'b0001: o_alu_cmd = 4'd8;  // EOR
          4'b1010: begin o_alu_cmd = 4'd4; o_wb_en = 1'b0; end  // CMP
          4'b1000: begin o_alu_cmd = 4'd6; o_wb_en = 1'b0; end  // TST
          default: begin o_wb_en = 1'b0; o_s_update = 1'b0; end
        endcase
      end
      2'b01: begin
        o_alu_cmd = 4'd2;
        if (i_s) begin
          o_mem_read = 1'b1;
          o_wb_en    = 1'b1;
        end else begin
          o_mem_write = 1'b1;
        end
      end
      2'b10:   o_branch = 1'b1;
      default: ;
    endcase
  end
endmodule

module id_stage_pipelined #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [3:0]        status,
  input  logic              hazard,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_cmd,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_en_out,
  output logic              branch,
  output logic              s_update,
  output logic              imm,
  output logic              two_src,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic [3:0]        dest,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [11:0]       shift_operand,
  output logic [23:0]       simm24,
  output logic [CNT_W-1:0]  kill_count
);
  logic [3:0]        w_alu_cmd;
  logic              w_mem_read, w_mem_write, w_wb_en, w_branch, w_s_update;
  logic              w_cond_ok, w_advance, w_accept, w_wb_ok;
  logic [3:0]        w_src1, w_src2;
  logic [DATA_W-1:0] w_rd1, w_rd2;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              r_valid, r_mem_read, r_mem_write, r_wb_en, r_branch, r_s_update, r_imm;
  logic [3:0]        r_alu_cmd, r_src1, r_src2, r_dest;
  logic [DATA_W-1:0] r_val1, r_val2;
  logic [11:0]       r_shift;
  logic [23:0]       r_simm24;
  logic [CNT_W-1:0]  r_kill;

  id_controller u_ctrl (
    .i_mode      (inst[27:26]),
    .i_opcode    (inst[24:21]),
    .i_s         (inst[20]),
    .o_alu_cmd   (w_alu_cmd),
    .o_mem_read  (w_mem_read),
    .o_mem_write (w_mem_write),
    .o_wb_en     (w_wb_en),
    .o_branch    (w_branch),
    .o_s_update  (w_s_update)
  );

  id_cond_check u_cond (
    .i_status (status),
    .i_cond   (inst[31:28]),
    .o_pass   (w_cond_ok)
  );

  // Stores read Rd as their second operand (the data to store).
  assign w_src1    = inst[19:16];
  assign w_src2    = w_mem_write ? inst[15:12] : inst[3:0];
  assign two_src   = !inst[25] || w_mem_write;
  assign w_advance = !r_valid || out_ready;
  assign in_ready  = w_advance && !hazard && !flush;
  assign w_accept  = in_valid && in_ready;
  // Widened compare keeps the range check meaningful when NUM_REGS is 16.
  assign w_wb_ok   = wb_en && ({1'b0, wb_dest} < 5'(NUM_REGS));

  // Register file write; unimplemented addresses are silently dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else if (w_wb_ok) begin
      for (int k = 0; k < NUM_REGS; k++)
        if (wb_dest == 4'(k)) r_regs[k] <= wb_value;
    end
  end

  // Combinational read ports with optional same-cycle write-back forwarding.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_src1 == 4'(k)) w_rd1 = r_regs[k];
      if (w_src2 == 4'(k)) w_rd2 = r_regs[k];
    end
    if (WB_BYPASS != 0 && w_wb_ok) begin
      if (wb_dest == w_src1) w_rd1 = wb_value;
      if (wb_dest == w_src2) w_rd2 = wb_value;
    end
  end

  // ID/EX slot: flush beats stall, stall holds everything, else load or bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_alu_cmd   <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_wb_en     <= 1'b0;
      r_branch    <= 1'b0;
      r_s_update  <= 1'b0;
      r_imm       <= 1'b0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_dest      <= '0;
      r_val1      <= '0;
      r_val2      <= '0;
      r_shift     <= '0;
      r_simm24    <= '0;
      r_kill      <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!w_advance) begin
      r_valid <= r_valid;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_alu_cmd   <= w_cond_ok ? w_alu_cmd   : 4'd0;
      r_mem_read  <= w_cond_ok && w_mem_read;
      r_mem_write <= w_cond_ok && w_mem_write;
      r_wb_en     <= w_cond_ok && w_wb_en;
      r_branch    <= w_cond_ok && w_branch;
      r_s_update  <= w_cond_ok && w_s_update;
      r_imm       <= inst[25];
      r_src1      <= w_src1;
      r_src2      <= w_src2;
      r_dest      <= inst[15:12];
      r_val1      <= w_rd1;
      r_val2      <= w_rd2;
      r_shift     <= inst[11:0];
      r_simm24    <= inst[23:0];
      if (!w_cond_ok && r_kill != '1) r_kill <= r_kill + 1'b1;
    end else begin
      r_valid     <= 1'b0;
      r_alu_cmd   <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_wb_en     <= 1'b0;
      r_branch    <= 1'b0;
      r_s_update  <= 1'b0;
    end
  end

  assign out_valid     = r_valid;
  assign alu_cmd       = r_alu_cmd;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign wb_en_out     = r_wb_en;
  assign branch        = r_branch;
  assign s_update      = r_s_update;
  assign imm           = r_imm;
  assign src1          = r_src1;
  assign src2          = r_src2;
  assign dest          = r_dest;
  assign val1          = r_val1;
  assign val2          = r_val2;
  assign shift_operand = r_shift;
  assign simm24        = r_simm24;
  assign kill_count    = r_kill;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Randomized bench for id_stage_pipelined against a table-driven reference
// model. Two instances share all inputs: one forwards write-back, one does not.
module tb_id_stage_pipelined;
  localparam int NR   = 12;
  localparam int KMAX = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, hazard, flush, wb_en, out_ready;
  logic [31:0] inst, wb_value;
  logic [3:0]  status, wb_dest;

  logic        in_ready, out_valid, mem_read, mem_write, wb_en_out, branch, s_update, imm, two_src;
  logic [3:0]  alu_cmd, src1, src2, dest;
  logic [31:0] val1, val2;
  logic [11:0] shift_operand;
  logic [23:0] simm24;
  logic [2:0]  kill_count;

  logic        n_in_ready, n_out_valid, n_mem_read, n_mem_write, n_wb_en_out, n_branch, n_s_update, n_imm, n_two_src;
  logic [3:0]  n_alu_cmd, n_src1, n_src2, n_dest;
  logic [31:0] n_val1, n_val2;
  logic [11:0] n_shift;
  logic [23:0] n_simm24;
  logic [2:0]  n_kill;

  always #5 clk = ~clk;

  id_stage_pipelined #(.DATA_W(32), .NUM_REGS(NR), .WB_BYPASS(1), .CNT_W(3)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .status(status),
    .hazard(hazard), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .out_valid(out_valid), .out_ready(out_ready), .alu_cmd(alu_cmd), .mem_read(mem_read),
    .mem_write(mem_write), .wb_en_out(wb_en_out), .branch(branch), .s_update(s_update), .imm(imm),
    .two_src(two_src), .src1(src1), .src2(src2), .dest(dest), .val1(val1), .val2(val2),
    .shift_operand(shift_operand), .simm24(simm24), .kill_count(kill_count));

  id_stage_pipelined #(.DATA_W(32), .NUM_REGS(NR), .WB_BYPASS(0), .CNT_W(3)) u_dut_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .inst(inst), .status(status),
    .hazard(hazard), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .out_valid(n_out_valid), .out_ready(out_ready), .alu_cmd(n_alu_cmd), .mem_read(n_mem_read),
    .mem_write(n_mem_write), .wb_en_out(n_wb_en_out), .branch(n_branch), .s_update(n_s_update),
    .imm(n_imm), .two_src(n_two_src), .src1(n_src1), .src2(n_src2), .dest(n_dest), .val1(n_val1),
    .val2(n_val2), .shift_operand(n_shift), .simm24(n_simm24), .kill_count(n_kill));

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state (what the slot should hold after the last edge).
  logic [31:0] m_regs [16];
  bit          e_v;
  logic [8:0]  e_ctl;  // {alu[3:0], mem_read, mem_write, wb_en, branch, s_update}
  logic        e_imm;
  logic [3:0]  e_s1, e_s2, e_d;
  logic [31:0] e_v1, e_v2, e_v1nb, e_v2nb;
  logic [11:0] e_sh;
  logic [23:0] e_simm;
  int          e_kill;

  // Data-processing opcode table: known?, ALU command, writes Rd?
  bit         op_known [16];
  logic [3:0] op_alu   [16];
  bit         op_wr    [16];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_op(input logic [3:0] op, input logic [3:0] alu, input bit wr);
    op_known[op] = 1'b1;
    op_alu[op]   = alu;
    op_wr[op]    = wr;
  endtask

  task automatic init_tables();
    for (int i = 0; i < 16; i++) begin op_known[i] = 0; op_alu[i] = 0; op_wr[i] = 0; end
    set_op(4'hD, 4'd1, 1); set_op(4'hF, 4'd9, 1); set_op(4'h4, 4'd2, 1);
    set_op(4'h5, 4'd3, 1); set_op(4'h2, 4'd4, 1); set_op(4'h6, 4'd5, 1);
    set_op(4'h0, 4'd6, 1); set_op(4'hC, 4'd7, 1); set_op(4'h1, 4'd8, 1);
    set_op(4'hA, 4'd4, 0); set_op(4'h8, 4'd6, 0);
  endtask

  function automatic logic [8:0] mdec(input logic [31:0] in);
    logic [1:0] mode = in[27:26];
    logic [3:0] op   = in[24:21];
    if (mode == 2'b01) return in[20] ? {4'd2, 5'b10100} : {4'd2, 5'b01000};
    if (mode == 2'b10) return {4'd0, 5'b00010};
    if (mode == 2'b00 && op_known[op]) return {op_alu[op], 2'b00, op_wr[op], 1'b0, in[20]};
    return 9'd0;
  endfunction

  // Conditions come in complementary pairs: even code tests, odd code inverts.
  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    bit base;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [31:0] mread(input logic [3:0] a, input bit byp);
    if (a >= NR) return 32'd0;
    if (byp && wb_en && wb_dest == a) return wb_value;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    e_v = 0; e_ctl = 0; e_imm = 0; e_s1 = 0; e_s2 = 0; e_d = 0;
    e_v1 = 0; e_v2 = 0; e_v1nb = 0; e_v2nb = 0; e_sh = 0; e_simm = 0; e_kill = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, e_v);
    chk({tag, "_ctl"}, {alu_cmd, mem_read, mem_write, wb_en_out, branch, s_update}, e_ctl);
    chk({tag, "_fields"}, {imm, src1, src2, dest, shift_operand, simm24}, {e_imm, e_s1, e_s2, e_d, e_sh, e_simm});
    chk({tag, "_val1"}, val1, e_v1);
    chk({tag, "_val2"}, val2, e_v2);
    chk({tag, "_kill"}, kill_count, e_kill);
    chk({tag, "_nb_val"}, {n_val1, n_val2}, {e_v1nb, e_v2nb});
    chk({tag, "_nb_rest"}, {n_out_valid, n_alu_cmd, n_mem_read, n_mem_write, n_wb_en_out, n_branch,
        n_s_update, n_imm, n_src1, n_src2, n_dest, n_shift, n_simm24, n_kill},
        {e_v, e_ctl, e_imm, e_s1, e_s2, e_d, e_sh, e_simm, 3'(e_kill)});
  endtask

  // One clock: inputs are already applied; check comb outputs, predict, clock, check slot.
  task automatic tick(input string tag);
    logic [8:0] ctl;
    logic [3:0] a2;
    bit adv, rdy;
    #1;
    ctl = mdec(inst);
    adv = !e_v || out_ready;
    rdy = adv && !hazard && !flush;
    chk({tag, "_in_ready"}, {in_ready, n_in_ready}, {rdy, rdy});
    chk({tag, "_two_src"}, {two_src, n_two_src}, {2{!inst[25] || ctl[3]}});
    a2 = ctl[3] ? inst[15:12] : inst[3:0];
    if (flush) e_v = 0;
    else if (!adv) ;
    else if (in_valid && rdy) begin
      e_v = 1;
      if (cond_pass(inst[31:28], status)) e_ctl = ctl;
      else begin
        e_ctl = 0;
        if (e_kill < KMAX) e_kill++;
      end
      e_imm = inst[25]; e_s1 = inst[19:16]; e_s2 = a2; e_d = inst[15:12];
      e_v1 = mread(inst[19:16], 1); e_v2 = mread(a2, 1);
      e_v1nb = mread(inst[19:16], 0); e_v2nb = mread(a2, 0);
      e_sh = inst[11:0]; e_simm = inst[23:0];
    end else begin
      e_v = 0; e_ctl = 0;
    end
    if (wb_en && wb_dest < NR) m_regs[wb_dest] = wb_value;
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle();
    in_valid = 0; hazard = 0; flush = 0; wb_en = 0; out_ready = 1;
    inst = 32'd0; status = 4'd0; wb_dest = 4'd0; wb_value = 32'd0;
  endtask

  task automatic rnd_inputs();
    int r;
    inst = $urandom;
    if ($urandom_range(0, 3) != 0) inst[31:28] = 4'hE;
    r = $urandom_range(0, 9);
    inst[27:26] = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
    status    = 4'($urandom);
    in_valid  = ($urandom_range(0, 9) < 8);
    out_ready = ($urandom_range(0, 3) != 0);
    hazard    = ($urandom_range(0, 19) < 3);
    flush     = ($urandom_range(0, 19) < 2);
    wb_en     = $urandom_range(0, 1) == 1;
    wb_dest   = 4'($urandom);
    wb_value  = $urandom;
  endtask

  initial begin
    init_tables();
    model_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 1'b1;

    // Load R1=5, R2=7 through write-back.
    wb_en = 1; wb_dest = 4'd1; wb_value = 32'd5; tick("wb1");
    wb_dest = 4'd2; wb_value = 32'd7; tick("wb2");
    wb_en = 0;

    // ADD R3,R1,R2 with one-cycle latency.
    in_valid = 1; inst = 32'hE0813002; tick("add");
    chk("add_v1", val1, 32'd5);
    chk("add_v2", val2, 32'd7);
    chk("add_dest", dest, 4'd3);
    chk("add_wb", {out_valid, wb_en_out}, 2'b11);

    // ADD R5,R4,R2 while R4 is written the same cycle.
    inst = 32'hE0845002; wb_en = 1; wb_dest = 4'd4; wb_value = 32'hDEADBEEF; tick("byp");
    chk("byp_v1", val1, 32'hDEADBEEF);
    chk("nobyp_v1", n_val1, 32'd0);
    wb_en = 0;

    // ADDEQ with Z=0 until the kill counter saturates.
    inst = 32'h00813002; status = 4'b0000; tick("kill");
    chk("kill_one", {out_valid, wb_en_out, kill_count}, {1'b1, 1'b0, 3'd1});
    repeat (8) tick("kill");
    chk("kill_sat", kill_count, 3'd7);

    // Back-pressure: valid slot, EX stalls for three cycles.
    status = 4'd0; inst = 32'hE0813002; tick("bp_fill");
    out_ready = 0; inst = 32'hE0845002;
    repeat (3) tick("bp_hold");
    chk("bp_frozen", {out_valid, val1}, {1'b1, 32'd5});
    out_ready = 1; tick("bp_release");
    chk("bp_new", val1, 32'hDEADBEEF);

    // One-cycle hazard bubble, then normal accept.
    hazard = 1; tick("haz");
    chk("haz_bubble", {out_valid, wb_en_out}, 2'b00);
    hazard = 0; tick("haz_after");

    // Flush beats hazard and a stalled EX.
    out_ready = 0; hazard = 1; flush = 1; tick("flush");
    chk("flush_clr", {out_valid, kill_count}, {1'b0, 3'd7});
    idle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rnd_inputs();
      tick("rnd");
    end

    // Async reset in the middle of a cycle, while EX is stalling a valid slot.
    idle();
    in_valid = 1; inst = 32'hE0813002; tick("pre_rst");
    out_ready = 0; in_valid = 0; tick("pre_rst_stall");
    #2 rst = 1'b0;
    #1 model_reset();
    check_outputs("arst");
    chk("arst_now", {out_valid, kill_count, val1}, 36'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1; in_valid = 1; inst = 32'hE0813002; tick("post_rst");
    chk("post_rst_regs", {val1, val2}, 64'd0);
    idle();
    tick("tail");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
